// File: rtl/debugger_arg_collector_if.sv
// debugger_arg_collector_if
//   Bundles the two four-phase handshakes around the argument collector.
//   The dispatcher side carries the request, line bounds and results
//   (req_n/start/length in, ack_n/argc/argv/error out). The converter side
//   carries hex_req_n/hex_start to a hex converter and hex_ack_n/hex_value/
//   hex_index back.
//   modport slave  : the collector's view.
//   modport master : the environment's view (dispatcher plus converter).
interface debugger_arg_collector_if #(
  parameter int COUNT    = 64,
  parameter int MAX_ARGS = 4
);
  localparam int IW = $clog2(COUNT + 1) + 1;
  localparam int AW = $clog2(MAX_ARGS + 1);

  // Dispatcher side
  logic                         req_n;
  logic [IW-1:0]                start;
  logic [IW-1:0]                length;
  logic                         ack_n;
  logic [AW-1:0]                argc;
  logic [MAX_ARGS-1:0][31:0]    argv;
  logic                         error;

  // Converter side
  logic                         hex_req_n;
  logic [IW-1:0]                hex_start;
  logic                         hex_ack_n;
  logic [31:0]                  hex_value;
  logic [IW-1:0]                hex_index;

  modport slave (
    input  req_n, start, length, hex_ack_n, hex_value, hex_index,
    output ack_n, argc, argv, error, hex_req_n, hex_start
  );

  modport master (
    output req_n, start, length, hex_ack_n, hex_value, hex_index,
    input  ack_n, argc, argv, error, hex_req_n, hex_start
  );
endinterface

// File: rtl/debugger_arg_collector.sv
// debugger_arg_collector
//   Walks one command line by running a hex converter repeatedly, storing
//   each returned value into the next argument slot. The converter reports
//   where its token ended; that index becomes the start of the next token.
//   Ports:
//     clk_i  : single clock, rising edge
//     rst_i  : synchronous, active-high reset
//     bus_if : dispatcher handshake + results, converter handshake
//   Every output is driven straight from a register.
module debugger_arg_collector #(
  parameter int COUNT    = 64,
  parameter int MAX_ARGS = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  debugger_arg_collector_if.slave  bus_if
);
  localparam int IW = $clog2(COUNT + 1) + 1;
  localparam int AW = $clog2(MAX_ARGS + 1);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_RELEASE, S_STORE, S_DONE, S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic          ack_n_q, ack_n_d;
  logic          hex_req_n_q, hex_req_n_d;
  logic [IW-1:0] hex_start_q, hex_start_d;
  logic [AW-1:0] argc_q, argc_d;
  logic          error_q, error_d;
  logic [IW-1:0] cursor_q, cursor_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          argv_clear;
  logic          argv_store;

  // Decision terms shared by the next-state and output logic
  logic start_empty, no_progress, at_end, slots_full, timed_out;

  always_comb begin
    start_empty = (bus_if.start >= bus_if.length) || (bus_if.start >= IW'(COUNT));
    // A converter that does not advance would loop forever on the same text
    no_progress = (bus_if.hex_index <= cursor_q);
    at_end      = (bus_if.hex_index >= bus_if.length) || (bus_if.hex_index >= IW'(COUNT));
    slots_full  = (argc_q == AW'(MAX_ARGS - 1));
    timed_out   = (timer_q == TW'(TIMEOUT));
  end

  // State register and all datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ack_n_q     <= 1'b1;
      hex_req_n_q <= 1'b1;
      hex_start_q <= '0;
      argc_q      <= '0;
      error_q     <= 1'b0;
      cursor_q    <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      ack_n_q     <= ack_n_d;
      hex_req_n_q <= hex_req_n_d;
      hex_start_q <= hex_start_d;
      argc_q      <= argc_d;
      error_q     <= error_d;
      cursor_q    <= cursor_d;
      timer_q     <= timer_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!bus_if.req_n) state_d = start_empty ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (!bus_if.hex_ack_n) state_d = S_RELEASE;
        else if (timed_out)    state_d = S_DRAIN;
      end
      S_RELEASE: begin
        if (bus_if.hex_ack_n)  state_d = S_STORE;
        else if (timed_out)    state_d = S_DRAIN;
      end
      S_STORE: begin
        if (no_progress || at_end || slots_full) state_d = S_DONE;
        else                                     state_d = S_ISSUE;
      end
      S_DONE: begin
        if (bus_if.req_n) state_d = S_IDLE;
      end
      S_DRAIN: begin
        // The converter must finish its own handshake before we report done
        if (bus_if.hex_ack_n) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    ack_n_d     = ack_n_q;
    hex_req_n_d = hex_req_n_q;
    hex_start_d = hex_start_q;
    argc_d      = argc_q;
    error_d     = error_q;
    cursor_d    = cursor_q;
    argv_clear  = 1'b0;
    argv_store  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!bus_if.req_n) begin
          ack_n_d    = 1'b0;
          argc_d     = '0;
          argv_clear = 1'b1;
          error_d    = 1'b0;
          cursor_d   = bus_if.start;
        end
      end
      S_ISSUE: begin
        hex_req_n_d = 1'b0;
        hex_start_d = cursor_q;
        if (bus_if.hex_ack_n && timed_out) begin
          hex_req_n_d = 1'b1;
          error_d     = 1'b1;
        end
      end
      S_RELEASE: begin
        hex_req_n_d = 1'b1;
        if (!bus_if.hex_ack_n && timed_out) error_d = 1'b1;
      end
      S_STORE: begin
        argv_store = 1'b1;
        argc_d     = argc_q + AW'(1);
        cursor_d   = bus_if.hex_index;
        // Reaching the end of the line with full slots is not an overflow
        if (no_progress || (!at_end && slots_full)) error_d = 1'b1;
      end
      S_DONE: begin
        if (bus_if.req_n) ack_n_d = 1'b1;
      end
      default: ;
    endcase

    // Timer restarts on every state change so each handshake phase gets
    // its own budget
    if ((state_d != state_q) || !((state_q == S_ISSUE) || (state_q == S_RELEASE)))
      timer_d = '0;
    else
      timer_d = timer_q + TW'(1);
  end

  // One register per argument slot, written only when it is the current slot
  for (genvar gi = 0; gi < MAX_ARGS; gi++) begin : g_slot
    logic [31:0] argv_q;

    always_ff @(posedge clk_i) begin
      if (rst_i || argv_clear)
        argv_q <= '0;
      else if (argv_store && (argc_q == AW'(gi)))
        argv_q <= bus_if.hex_value;
    end

    assign bus_if.argv[gi] = argv_q;
  end

  assign bus_if.ack_n     = ack_n_q;
  assign bus_if.argc      = argc_q;
  assign bus_if.error     = error_q;
  assign bus_if.hex_req_n = hex_req_n_q;
  assign bus_if.hex_start = hex_start_q;
endmodule

// File: tb/tb_debugger_arg_collector.sv
module tb_debugger_arg_collector;
  localparam int COUNT    = 64;
  localparam int MAX_ARGS = 4;
  localparam int TIMEOUT  = 10;
  localparam int IW       = $clog2(COUNT + 1) + 1;
  localparam int AW       = $clog2(MAX_ARGS + 1);
  localparam int NV       = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debugger_arg_collector_if #(.COUNT(COUNT), .MAX_ARGS(MAX_ARGS)) bus();

  debugger_arg_collector #(.COUNT(COUNT), .MAX_ARGS(MAX_ARGS), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_if(bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- line buffer and converter model ----------------
  byte line_mem [COUNT];
  int  conv_mode;  // 0 real converter, 1 never acknowledges, 2 returns index=start

  function automatic int hexval(input byte c);
    if (c >= "0" && c <= "9") return int'(c) - int'("0");
    if (c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
    if (c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
    return -1;
  endfunction

  function automatic void parse(input int s, input int l, output logic [31:0] v, output int idx);
    int lim;
    int i;
    lim = (l < COUNT) ? l : COUNT;
    i = s;
    v = '0;
    while (i < lim && line_mem[i] == 8'h20) i++;
    while (i < lim && hexval(line_mem[i]) >= 0) begin
      v = {v[27:0], 4'(hexval(line_mem[i]))};
      i++;
    end
    while (i < lim && line_mem[i] == 8'h20) i++;
    if (i < lim && line_mem[i] == 8'h2C) i++;
    idx = i;
  endfunction

  task automatic load_line(input string str, input int at);
    for (int i = 0; i < COUNT; i++) line_mem[i] = 8'h2E;
    for (int j = 0; j < str.len(); j++)
      if (at + j < COUNT) line_mem[at + j] = str[j];
  endtask

  typedef enum {C_IDLE, C_WORK, C_HELD, C_REL} cst_t;
  cst_t        cst;
  int          ccnt;
  logic [31:0] pv;
  int          pidx;

  always @(posedge clk) begin
    if (rst) begin
      cst           <= C_IDLE;
      ccnt          <= 0;
      bus.hex_ack_n <= 1'b1;
      bus.hex_value <= '0;
      bus.hex_index <= '0;
    end else begin
      case (cst)
        C_IDLE: if (!bus.hex_req_n && conv_mode != 1) begin
          ccnt <= int'($urandom_range(0, 3));
          cst  <= C_WORK;
        end
        C_WORK: if (ccnt == 0) begin
          if (conv_mode == 2) begin
            bus.hex_value <= 32'h1234;
            bus.hex_index <= bus.hex_start;
          end else begin
            parse(int'(bus.hex_start), int'(bus.length), pv, pidx);
            bus.hex_value <= pv;
            bus.hex_index <= IW'(pidx);
          end
          bus.hex_ack_n <= 1'b0;
          cst <= C_HELD;
        end else ccnt <= ccnt - 1;
        C_HELD: if (bus.hex_req_n) begin
          ccnt <= int'($urandom_range(0, 2));
          cst  <= C_REL;
        end
        C_REL: if (ccnt == 0) begin
          bus.hex_ack_n <= 1'b1;
          cst <= C_IDLE;
        end else ccnt <= ccnt - 1;
        default: cst <= C_IDLE;
      endcase
    end
  end

  // ---------------- converter-side monitor ----------------
  int            hs_count;
  int            low_cycles;
  logic          prev_req = 1'b1;
  logic [IW-1:0] prev_start = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_req && !bus.hex_req_n) hs_count++;
      if (!bus.hex_req_n) low_cycles++;
      if (!prev_req && !bus.hex_req_n) check("hex_start_stable", 32'(bus.hex_start), 32'(prev_start));
    end
    prev_req   = bus.hex_req_n;
    prev_start = bus.hex_start;
  end

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    int          at;
    int          s;
    int          l;
    int          mode;
    int          argc;
    logic [31:0] a0, a1, a2, a3;
    bit          err;
    int          hs;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0]             argc;
    logic [MAX_ARGS-1:0][31:0] argv;
    logic                      err;
    logic [7:0]                hs;
  } exp_t;

  vec_t  vt [NV];
  string lines [NV];
  exp_t  sb_q [$];

  function automatic vec_t mk(input int at, input int s, input int l, input int mode, input int argc,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3,
                              input bit err, input int hs);
    vec_t v;
    v.at = at; v.s = s; v.l = l; v.mode = mode; v.argc = argc;
    v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3; v.err = err; v.hs = hs;
    return v;
  endfunction

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.argc    = AW'(v.argc);
    e.argv[0] = v.a0;
    e.argv[1] = v.a1;
    e.argv[2] = v.a2;
    e.argv[3] = v.a3;
    e.err     = v.err;
    e.hs      = 8'(v.hs);
    return e;
  endfunction

  task automatic wait_ack_high(output int waited);
    waited = -1;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (bus.ack_n === 1'b1) begin
        waited = i;
        break;
      end
    end
    if (waited < 0) check("ack_n_rise_timeout", 32'(bus.ack_n), 32'd1);
  endtask

  // Drives one dispatcher request, raising REQ_n early, then compares the
  // results against the oldest scoreboard entry.
  task automatic run_request(input int s, input int l, input bit empty, input string tag);
    exp_t e;
    int   waited;
    @(negedge clk);
    #2;
    hs_count   = 0;
    low_cycles = 0;
    bus.start  = IW'(s);
    bus.length = IW'(l);
    bus.req_n  = 1'b0;
    @(negedge clk);
    check({tag, "/ack_n_low"}, 32'(bus.ack_n), 32'd0);
    check({tag, "/hex_req_n_n1"}, 32'(bus.hex_req_n), 32'd1);
    @(negedge clk);
    check({tag, "/hex_req_n_n2"}, 32'(bus.hex_req_n), empty ? 32'd1 : 32'd0);
    bus.req_n = 1'b1;
    wait_ack_high(waited);
    if (empty) check({tag, "/empty_ack_latency"}, 32'(waited), 32'd1);
    e = sb_q.pop_front();
    check({tag, "/argc"},  32'(bus.argc), 32'(e.argc));
    for (int k = 0; k < MAX_ARGS; k++)
      check($sformatf("%s/argv%0d", tag, k), bus.argv[k], e.argv[k]);
    check({tag, "/error"}, 32'(bus.error), 32'(e.err));
    check({tag, "/handshakes"}, 32'(hs_count), 32'(e.hs));
    $display("txn %s: argc=%0d argv=%h_%h_%h_%h error=%0d handshakes=%0d",
             tag, bus.argc, bus.argv[0], bus.argv[1], bus.argv[2], bus.argv[3],
             bus.error, hs_count);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ok;
    rst        = 1'b1;
    bus.req_n  = 1'b1;
    bus.start  = '0;
    bus.length = '0;
    conv_mode  = 0;
    hs_count   = 0;
    low_cycles = 0;
    load_line("", 0);

    lines[0]  = "10,20";              vt[0]  = mk(0, 0, 5, 0, 2, 32'h10, 32'h20, 0, 0, 0, 2);
    lines[1]  = "  AB ,  cd";         vt[1]  = mk(0, 0, 10, 0, 2, 32'hAB, 32'hCD, 0, 0, 0, 2);
    lines[2]  = "5,";                 vt[2]  = mk(0, 0, 2, 0, 1, 32'h5, 0, 0, 0, 0, 1);
    lines[3]  = "1 2 3 4 5";          vt[3]  = mk(0, 0, 9, 0, 4, 32'h1, 32'h2, 32'h3, 32'h4, 1, 4);
    lines[4]  = "1 2 3 4 5";          vt[4]  = mk(0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    lines[5]  = "abc";                vt[5]  = mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 1, 1);
    lines[6]  = "abc";                vt[6]  = mk(0, 0, 3, 2, 1, 32'h1234, 0, 0, 0, 1, 1);
    lines[7]  = "ffffffff,0 12";      vt[7]  = mk(0, 0, 13, 0, 3, 32'hFFFFFFFF, 32'h0, 32'h12, 0, 0, 3);
    lines[8]  = "x 1,2";              vt[8]  = mk(0, 2, 5, 0, 2, 32'h1, 32'h2, 0, 0, 0, 2);
    lines[9]  = "7 ";                 vt[9]  = mk(62, 62, 70, 0, 1, 32'h7, 0, 0, 0, 0, 1);
    lines[10] = "12";                 vt[10] = mk(0, 64, 70, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/ack_n",     32'(bus.ack_n), 32'd1);
    check("reset/hex_req_n", 32'(bus.hex_req_n), 32'd1);
    check("reset/hex_start", 32'(bus.hex_start), 32'd0);
    check("reset/argc",      32'(bus.argc), 32'd0);
    check("reset/argv0",     bus.argv[0], 32'd0);
    check("reset/argv3",     bus.argv[3], 32'd0);
    check("reset/error",     32'(bus.error), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < NV; v++) begin
      load_line(lines[v], vt[v].at);
      conv_mode = vt[v].mode;
      sb_q.push_back(to_exp(vt[v]));
      run_request(vt[v].s, vt[v].l, vt[v].hs == 0, $sformatf("vec%0d", v));
      // A silent converter keeps HEX_REQ_n low for TIMEOUT cycles before the
      // collector gives up and releases it.
      if (vt[v].mode == 1) check("timeout/hex_req_low_cycles", 32'(low_cycles), 32'(TIMEOUT));
    end

    // Reset while waiting in RELEASE on the second argument
    conv_mode = 0;
    load_line("1 2 3", 0);
    @(negedge clk);
    #2;
    hs_count   = 0;
    bus.start  = '0;
    bus.length = IW'(5);
    bus.req_n  = 1'b0;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (hs_count == 2 && bus.hex_req_n === 1'b1 && bus.hex_ack_n === 1'b0) begin
        ok = 1;
        break;
      end
    end
    check("midreset/reached_release", 32'(ok), 32'd1);
    rst       = 1'b1;
    bus.req_n = 1'b1;
    @(negedge clk);
    check("midreset/hex_req_n", 32'(bus.hex_req_n), 32'd1);
    check("midreset/ack_n",     32'(bus.ack_n), 32'd1);
    check("midreset/argc",      32'(bus.argc), 32'd0);
    check("midreset/error",     32'(bus.error), 32'd0);
    check("midreset/argv0",     bus.argv[0], 32'd0);
    rst = 1'b0;
    $display("txn midreset: collector back to idle");

    load_line("FF", 0);
    sb_q.push_back(to_exp(mk(0, 0, 2, 0, 1, 32'hFF, 0, 0, 0, 0, 1)));
    run_request(0, 2, 1'b0, "after_reset_FF");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/debugger_arg_collector.md
# debugger_arg_collector

Sequencer that drives the debugger's hex-to-value converter repeatedly over one command line, collecting up to `MAX_ARGS` 32-bit hex arguments into a register file. It sits between the command dispatcher, which supplies the line buffer start/length and reads `ARGC`/`ARGV`, and a single converter instance, whose request/acknowledge handshake it owns. The converter's `DATA` and `LENGTH` inputs are wired directly from the line buffer and are not routed through this block.

## Interface
- `COUNT`, 64: line buffer size in characters; index width is `IW = $clog2(COUNT+1)+1`.
- `MAX_ARGS`, 4: number of argument slots.
- `TIMEOUT`, 255: maximum cycles spent waiting in any single converter handshake phase.
- `CLK`  in  1  single clock; all logic on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `REQ_n`  in  1  dispatcher request, active low, four-phase.
- `START`  in  IW  first character index of the argument field.
- `LENGTH`  in  IW  line length; parsing ends at `LENGTH` or `COUNT`.
- `ACK_n`  out  1  acknowledge, active low.
- `ARGC`  out  `$clog2(MAX_ARGS+1)`  number of arguments stored.
- `ARGV[0:MAX_ARGS-1]`  out  32 each  argument values.
- `ERROR`  out  1  set on overflow, no-progress, or timeout.
- `HEX_REQ_n`  out  1  converter request, active low.
- `HEX_START`  out  IW  converter start index.
- `HEX_ACK_n`  in  1  converter acknowledge.
- `HEX_VALUE`  in  32  converter result.
- `HEX_INDEX`  in  IW  converter end index, which is the start of the next token.

## Operation
- Four-phase handshake, on both sides:
  - Requester drops `REQ_n`; responder drops `ACK_n`.
  - Requester raises `REQ_n`; responder raises `ACK_n` only when the work is complete.
  - Results are valid from `ACK_n` rising until the next accepted request.
- Reset values: `ACK_n=1`, `HEX_REQ_n=1`, `HEX_START=0`, `ARGC=0`, all `ARGV=0`, `ERROR=0`, cursor=0, timer=0, state `IDLE`.
- States:
  - `IDLE`: on `REQ_n=0`, set `ACK_n<=0`, `ARGC<=0`, all `ARGV<=0`, `ERROR<=0`, cursor<=`START`.
    - If `START>=LENGTH` or `START>=COUNT`, go to `DONE`.
    - Otherwise go to `ISSUE`.
  - `ISSUE`: `HEX_REQ_n<=0`, `HEX_START<=cursor`, timer cleared. Wait for `HEX_ACK_n=0`, then go to `RELEASE`.
  - `RELEASE`: `HEX_REQ_n<=1`, timer cleared. Wait for `HEX_ACK_n=1`, then go to `STORE`.
  - `STORE`: `ARGV[ARGC]<=HEX_VALUE`, `ARGC<=ARGC+1`, cursor<=`HEX_INDEX`. Then, in priority order:
    - `HEX_INDEX<=cursor` (no progress): `ERROR<=1` → `DONE`.
    - `HEX_INDEX>=LENGTH` or `HEX_INDEX>=COUNT`: → `DONE`.
    - `ARGC+1==MAX_ARGS` (slots full, text remains): `ERROR<=1` → `DONE`.
    - Otherwise → `ISSUE`.
  - `DONE`: wait for `REQ_n=1`, then `ACK_n<=1` → `IDLE`.
- Timeout: in `ISSUE` or `RELEASE`, if the timer reaches `TIMEOUT`, set `ERROR<=1`, force `HEX_REQ_n<=1`, and go to `DRAIN`.
  - `DRAIN` waits for `HEX_ACK_n=1` with no time limit, then goes to `DONE`. `ARGC`/`ARGV` keep the values already stored.
- `ARGC` never exceeds `MAX_ARGS`. Slots that are not written read 0.
- If `REQ_n` is raised before completion, the sequence continues; `ACK_n` rises only after `DONE`.
- `RESET` mid-operation returns everything to reset values within one cycle, including `HEX_REQ_n=1`. The converter has its own reset.

## Timing
- Request sampled at edge N gives `ACK_n=0` at N+1. `HEX_REQ_n=0` appears at N+2 when the line is non-empty.
- Per-argument overhead beyond converter latency:
  - 1 cycle from `HEX_ACK_n` falling to `HEX_REQ_n` rising.
  - 1 cycle from `HEX_ACK_n` rising to `STORE`.
  - 1 cycle from `STORE` to the next `HEX_REQ_n=0`.
- Empty line: `ACK_n` rises 1 cycle after `REQ_n=1` is sampled in `DONE`; zero converter handshakes are issued.
- `HEX_START` is stable whenever `HEX_REQ_n=0`.
- Outputs are registered; no combinational path from any input to any output.

## Test plan
- Line "10,20", `START=0`, `LENGTH=5`, real converter → `ARGC=2`, `ARGV0=0x10`, `ARGV1=0x20`, `ERROR=0`, exactly 2 converter handshakes.
- Line "  AB ,  cd" (`LENGTH=10`) → `ARGC=2`, `ARGV0=0xAB`, `ARGV1=0xCD`, `ERROR=0`. Line "5," → `ARGC=1`, `ARGV0=5`, `ERROR=0`.
- Line "1 2 3 4 5", `MAX_ARGS=4` → `ARGC=4`, `ARGV3=4`, `ERROR=1`, no fifth handshake.
- `START=LENGTH=7` → `ARGC=0`, all `ARGV=0`, `ERROR=0`, `HEX_REQ_n` never low; previous results cleared.
- Stub converter never asserting `HEX_ACK_n`, `TIMEOUT=10` → `ERROR=1` after 11 cycles in `ISSUE`, `HEX_REQ_n` returns to 1, `ACK_n` completes the handshake. Stub returning `HEX_INDEX=START` → `ERROR=1`, `ARGC=1`.
- `RESET` pulsed while in `RELEASE` during the second argument → next cycle: `HEX_REQ_n=1`, `ACK_n=1`, `ARGC=0`, `ERROR=0`. A subsequent request on "FF" yields `ARGC=1`, `ARGV0=0xFF`.
